// File: rtl/operand_serial_shift_reg.sv
// rtl/operand_serial_shift_reg.sv - parallel-in/serial-out operand register for the serial adder
// Loads a WIDTH-bit operand (optionally inverted for subtract) and streams it one bit per enabled edge.
module operand_serial_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       CLK,
    input  logic                       R,
    input  logic                       L,
    input  logic [WIDTH-1:0]           Load,
    input  logic                       INV,
    input  logic                       EN,
    output logic                       Sout,
    output logic                       Cin,
    output logic                       VALID,
    output logic                       DONE,
    output logic [$clog2(WIDTH+1)-1:0] CNT
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             inv_q;
    logic             head;

    // Load wins over shift, so a reload on the last consuming edge never reaches DONE.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            inv_q <= 1'b0;
        end else if (L) begin
            state <= ST_SHIFT;
            sreg  <= INV ? ~Load : Load;
            cnt   <= '0;
            inv_q <= INV;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (EN) begin
                        sreg <= LSB_FIRST ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH-1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
    assign VALID = (state == ST_SHIFT);
    assign DONE  = (state == ST_DONE);
    assign Sout  = VALID & head;
    assign Cin   = VALID & inv_q & (cnt == '0);
    assign CNT   = cnt;

endmodule

// File: tb/tb_operand_serial_shift_reg.sv
// tb/tb_operand_serial_shift_reg.sv - scoreboard bench for operand_serial_shift_reg
// Three instances (8/LSB, 4/MSB, 16/LSB) share clock and reset; a negedge monitor checks each against queued bits.
module tb_operand_serial_shift_reg;

    logic CLK = 1'b0;
    logic R   = 1'b1;
    always #5 CLK = ~CLK;

    logic        l_a   [3];
    logic        inv_a [3];
    logic        en_a  [3];
    logic [15:0] ld_a  [3];
    logic        sout_a  [3];
    logic        cin_a   [3];
    logic        valid_a [3];
    logic        done_a  [3];
    logic [4:0]  cnt_a   [3];
    logic [3:0]  cnt8;
    logic [2:0]  cnt4;
    logic [4:0]  cnt16;

    int widths [3] = '{8, 4, 16};
    bit lsbf   [3] = '{1'b1, 1'b0, 1'b1};

    operand_serial_shift_reg #(.WIDTH(8), .LSB_FIRST(1'b1)) d8 (
        .CLK(CLK), .R(R), .L(l_a[0]), .Load(ld_a[0][7:0]), .INV(inv_a[0]), .EN(en_a[0]),
        .Sout(sout_a[0]), .Cin(cin_a[0]), .VALID(valid_a[0]), .DONE(done_a[0]), .CNT(cnt8));
    operand_serial_shift_reg #(.WIDTH(4), .LSB_FIRST(1'b0)) d4 (
        .CLK(CLK), .R(R), .L(l_a[1]), .Load(ld_a[1][3:0]), .INV(inv_a[1]), .EN(en_a[1]),
        .Sout(sout_a[1]), .Cin(cin_a[1]), .VALID(valid_a[1]), .DONE(done_a[1]), .CNT(cnt4));
    operand_serial_shift_reg #(.WIDTH(16), .LSB_FIRST(1'b1)) d16 (
        .CLK(CLK), .R(R), .L(l_a[2]), .Load(ld_a[2]), .INV(inv_a[2]), .EN(en_a[2]),
        .Sout(sout_a[2]), .Cin(cin_a[2]), .VALID(valid_a[2]), .DONE(done_a[2]), .CNT(cnt16));

    assign cnt_a[0] = 5'(cnt8);
    assign cnt_a[1] = 5'(cnt4);
    assign cnt_a[2] = cnt16;

    typedef struct packed {
        logic       b;
        logic       c;
        logic [4:0] n;
    } exp_t;

    exp_t        q    [3][$];
    logic        got  [3][$];
    bit          loaded [3];
    bit          pend   [3];
    logic [15:0] pv     [3];
    bit          pi     [3];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Reference: the stream is simply the (possibly inverted) operand read out in bit order.
    task automatic model_load(input int k);
        logic [15:0] val;
        exp_t        e;
        int          idx;
        val = pi[k] ? ~pv[k] : pv[k];
        q[k].delete();
        got[k].delete();
        loaded[k] = 1'b1;
        for (int i = 0; i < widths[k]; i++) begin
            idx = lsbf[k] ? i : widths[k] - 1 - i;
            e.b = val[idx];
            e.c = pi[k] && (i == 0);
            e.n = 5'(i);
            q[k].push_back(e);
        end
    endtask

    task automatic start_load(input int k, input logic [15:0] v, input bit iv);
        ld_a[k]  = v;
        inv_a[k] = iv;
        l_a[k]   = 1'b1;
        pv[k]    = v;
        pi[k]    = iv;
        pend[k]  = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (pend[k]) begin
                l_a[k]  = 1'b0;
                pend[k] = 1'b0;
                model_load(k);
            end
        end
    endtask

    function automatic logic [15:0] packed_got(input int k);
        logic [15:0] w;
        int          n;
        w = '0;
        n = got[k].size();
        for (int i = 0; i < n; i++) begin
            if (lsbf[k]) w[i] = got[k][i];
            else         w[n-1-i] = got[k][i];
        end
        return w;
    endfunction

    task automatic chk_stream(input string name, input int k, input logic [15:0] exp);
        chk({name, "_len"}, k, got[k].size(), widths[k]);
        chk(name, k, packed_got(k), exp);
    endtask

    always @(negedge CLK) begin
        bit   ev;
        bit   ed;
        logic es;
        logic ec;
        int   ecnt;
        for (int k = 0; k < 3; k++) begin
            ev   = q[k].size() > 0;
            ed   = loaded[k] && (q[k].size() == 0);
            es   = ev ? q[k][0].b : 1'b0;
            ec   = ev ? q[k][0].c : 1'b0;
            ecnt = ev ? int'(q[k][0].n) : (ed ? widths[k] : 0);
            chk("valid", k, valid_a[k], ev);
            chk("done",  k, done_a[k],  ed);
            chk("sout",  k, sout_a[k],  es);
            chk("cin",   k, cin_a[k],   ec);
            chk("cnt",   k, cnt_a[k],   ecnt);
            if (ev && en_a[k] && !l_a[k] && !R) begin
                got[k].push_back(sout_a[k]);
                void'(q[k].pop_front());
            end
        end
    end

    initial begin
        int pat [6] = '{1, 0, 1, 0, 1, 1};
        for (int k = 0; k < 3; k++) begin
            l_a[k] = 1'b0; inv_a[k] = 1'b0; en_a[k] = 1'b0; ld_a[k] = '0;
            loaded[k] = 1'b0; pend[k] = 1'b0;
        end
        repeat (2) tick();
        R = 1'b0;
        tick();

        start_load(0, 16'h00A4, 1'b0);
        tick();
        en_a[0] = 1'b1;
        repeat (11) tick();
        en_a[0] = 1'b0;
        chk_stream("plain8", 0, 16'h00A4);

        start_load(0, 16'h006D, 1'b1);
        tick();
        en_a[0] = 1'b1;
        repeat (9) tick();
        en_a[0] = 1'b0;
        chk_stream("inv8", 0, 16'h0092);

        start_load(1, 16'h000D, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            en_a[1] = pat[i][0];
            tick();
        end
        en_a[1] = 1'b0;
        repeat (2) tick();
        chk_stream("msb4", 1, 16'h000D);

        start_load(0, 16'h00A5, 1'b0);
        tick();
        en_a[0] = 1'b1;
        repeat (3) tick();
        start_load(0, 16'h003C, 1'b0);
        tick();
        repeat (9) tick();
        en_a[0] = 1'b0;
        chk_stream("reload", 0, 16'h003C);

        start_load(2, 16'h8001, 1'b0);
        tick();
        en_a[2] = 1'b1;
        repeat (18) tick();
        en_a[2] = 1'b0;
        chk_stream("w16", 2, 16'h8001);

        start_load(0, 16'h00FF, 1'b0);
        start_load(2, 16'hFFFF, 1'b1);
        tick();
        en_a[0] = 1'b1;
        en_a[2] = 1'b1;
        repeat (5) tick();
        #2;
        R = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_sout",  k, sout_a[k],  1'b0);
            chk("rst_valid", k, valid_a[k], 1'b0);
            chk("rst_cin",   k, cin_a[k],   1'b0);
            chk("rst_done",  k, done_a[k],  1'b0);
            chk("rst_cnt",   k, cnt_a[k],   0);
            q[k].delete();
            got[k].delete();
            loaded[k] = 1'b0;
        end
        repeat (2) tick();
        R = 1'b0;
        for (int k = 0; k < 3; k++) en_a[k] = 1'b1;
        repeat (4) tick();

        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 11) == 0)
                    start_load(k, 16'($urandom), 1'($urandom_range(0, 1)));
                en_a[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) en_a[k] = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_serial_shift_reg.md
# operand_serial_shift_reg

Parametrised parallel-in/serial-out operand register for the Capstone serial arithmetic datapath. It captures a WIDTH-bit operand and streams it one bit per enabled clock, LSB-first or MSB-first. It can invert the operand at load time and flag the carry-in, so the serial adder can subtract (A + ~B + 1). It replaces the fixed 8-bit addend and subtrahend shift registers with a single block that adds a shift-enable, a bit counter and end-of-operand status.

## Interface
Parameters:
- WIDTH, 8: operand width in bits. Must be ≥ 2.
- LSB_FIRST, 1: 1 streams bit 0 first; 0 streams bit WIDTH-1 first.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- R  in  1  reset, asynchronous, active-high.
- L  in  1  load strobe; samples Load and INV on the rising edge.
- Load  in  WIDTH  parallel operand.
- INV  in  1  sampled with L; 1 stores ~Load and arms the carry-in flag (subtract).
- EN  in  1  shift enable; advances one bit per rising edge while streaming.
- Sout  out  1  current serial bit.
- Cin  out  1  carry-in request for the serial adder; high only while the first bit is presented and INV was set.
- VALID  out  1  Sout carries an operand bit this cycle.
- DONE  out  1  all WIDTH bits consumed; held until the next load or reset.
- CNT  out  $clog2(WIDTH+1)  number of bits already shifted out.

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- Reset (asynchronous, any time including mid-stream):
  - Shift register = 0, CNT = 0, INV latch = 0, state = IDLE.
  - Outputs: Sout = 0, Cin = 0, VALID = 0, DONE = 0.
- L = 1 in any state:
  - Shift register ← INV ? ~Load : Load.
  - INV latch ← INV, CNT ← 0, state → SHIFT.
  - L has priority over EN. A load coinciding with EN performs no shift.
  - A load in SHIFT aborts the current operand with no error indication.
- SHIFT with EN = 1 and L = 0:
  - LSB_FIRST = 1: register shifts right, zero fills the MSB.
  - LSB_FIRST = 0: register shifts left, zero fills the LSB.
  - CNT increments.
  - If CNT = WIDTH-1 before the edge, state → DONE and CNT = WIDTH.
- SHIFT with EN = 0: everything holds. Stalls of any length are allowed.
- DONE:
  - EN is ignored; the register and CNT hold.
  - Only L or R leaves DONE.
- IDLE: EN is ignored.
- Output decode:
  - Sout = head bit (bit 0 if LSB_FIRST, else bit WIDTH-1) when in SHIFT; 0 in IDLE and DONE.
  - VALID = (state == SHIFT).
  - DONE = (state == DONE).
  - Cin = VALID & INV latch & (CNT == 0).
- All outputs are decoded combinationally from registered state. There is no combinational path from any input to any output.

## Timing
- Load-to-first-bit latency: 1 cycle. Sout, VALID and Cin are valid after the loading edge.
- Each bit is presented until the rising edge at which EN = 1. The consumer samples Sout on that same edge.
- With EN held high, a full operand takes WIDTH cycles after the load edge. DONE rises after the WIDTH-th enabled edge.
- Back-to-back operation: asserting L on the same edge that consumes the last bit reloads the register (L priority). DONE does not rise, and the new operand's first bit appears on the next cycle.
- Reset asserted mid-stream clears all outputs immediately, without waiting for a clock edge. Deassertion returns the block to IDLE; the first L after deassertion behaves normally.

## Test plan
- WIDTH=8, LSB_FIRST=1. Load 8'b10100100 with INV=0, then hold EN=1.
  - Sout sequence: 0,0,1,0,0,1,0,1.
  - Cin stays 0; CNT steps 0..8.
  - DONE rises after the 8th enable and holds while EN stays high.
- WIDTH=8. Load 8'b01101101 with INV=1, then hold EN=1.
  - Sout sequence: 0,1,0,0,1,0,0,1 (bits of 8'b10010010).
  - Cin = 1 for the first bit only.
- WIDTH=4, LSB_FIRST=0. Load 4'b1101 and toggle EN 1,0,1,0,1,1.
  - Sout presents 1,1,0,1, holding each bit through the EN=0 cycles.
  - CNT holds during stalls; DONE rises after the 4th enabled edge.
- Load 8'hA5 and shift 3 bits, then assert L with Load=8'h3C and EN=1 on the same edge.
  - No shift occurs on that edge; CNT = 0.
  - Stream restarts with 0,0,1,1,1,1,0,0.
- Assert R mid-stream, after 5 bits, between clock edges.
  - Sout, VALID, Cin, DONE and CNT go to 0 immediately.
  - EN pulses afterwards produce no VALID until the next L.
- WIDTH=16. Load 16'h8001 with INV=0.
  - Sout: 1, fourteen 0s, then 1; DONE after 16 enabled edges.
  - CNT reaches 16 within its 5-bit range.
